// File: rtl/regfile_sequencer.sv
// Initiator for the 2-bit RW register-file command interface: READ -> EXEC -> WRITE per instruction.
// Optional multiply (op C) is built only when REGSEQ_MUL_EN is defined.
module regfile_sequencer #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             rf_en,
  output logic [1:0]       rf_rw,
  output logic [AW-1:0]    rf_da,
  output logic [AW-1:0]    rf_aa,
  output logic [AW-1:0]    rf_ba,
  output logic [WIDTH-1:0] rf_d,
  input  logic [WIDTH-1:0] rf_a,
  input  logic [WIDTH-1:0] rf_b,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t           state, state_nxt;
  logic [15:0]      ir;
  logic             accept;
  logic [WIDTH:0]   alu_out;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    ok = (op >= 4'h1) && (op <= 4'h9);
`ifdef REGSEQ_MUL_EN
    if (op == 4'hC) ok = 1'b1;
`endif
    return ok;
  endfunction

  // Returns {carry/borrow, value}; carry is forced to 0 for logic/shift ops.
  function automatic logic [WIDTH:0] alu(input logic [3:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
`ifdef REGSEQ_MUL_EN
    logic [2*WIDTH-1:0] prod;
    prod = a * b;
`endif
    r = '0;
    case (op)
      4'h1: r = {1'b0, a} + {1'b0, b};
      4'h2: r = {(a < b), a - b};
      4'h3: r = {1'b0, a & b};
      4'h4: r = {1'b0, a | b};
      4'h5: r = {1'b0, a ^ b};
      4'h6: r = {1'b0, a};
      4'h7: r = {1'b0, ~a};
      4'h8: r = {1'b0, a[WIDTH-2:0], 1'b0};
      4'h9: r = {2'b00, a[WIDTH-1:1]};
`ifdef REGSEQ_MUL_EN
      4'hC: r = {(|prod[2*WIDTH-1:WIDTH]), prod[WIDTH-1:0]};
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  assign instr_ready = (state == IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;
  assign alu_out     = alu(ir[15:12], rf_a, rf_b);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && op_legal(instr[15:12])) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ir     <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == WRITE) || (accept && !op_legal(instr[15:12]));
      err   <= accept && (instr[15:12] != 4'h0) && !op_legal(instr[15:12]);
      if (accept) ir <= instr;
      // EXEC boundary: operands from the read issued last cycle are live now
      if (state == EXEC) begin
        result <= alu_out[WIDTH-1:0];
        flag_c <= alu_out[WIDTH];
        flag_z <= (alu_out[WIDTH-1:0] == '0);
      end
    end
  end

  // Register-file command decode; rf_en is forced high during reset so the file clears.
  always_comb begin
    rf_en = rst;
    rf_rw = 2'b00;
    rf_da = '0;
    rf_aa = '0;
    rf_ba = '0;
    rf_d  = '0;
    if (!rst) begin
      case (state)
        READ: begin
          rf_en = 1'b1;
          rf_rw = 2'b10;
          rf_aa = ir[4 +: AW];
          rf_ba = ir[0 +: AW];
        end
        WRITE: begin
          rf_en = 1'b1;
          rf_rw = 2'b01;
          rf_da = ir[8 +: AW];
          rf_d  = result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: stimulus pushes expected retirements, a
// negedge monitor pops them on done and checks rf traffic, latency and results.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        rf_en;
  logic [1:0]  rf_rw;
  logic [3:0]  rf_da, rf_aa, rf_ba;
  logic [15:0] rf_d, rf_a, rf_b, result;
  logic        flag_z, flag_c, done, err;

  regfile_sequencer #(.WIDTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .rf_en(rf_en), .rf_rw(rf_rw), .rf_da(rf_da),
    .rf_aa(rf_aa), .rf_ba(rf_ba), .rf_d(rf_d), .rf_a(rf_a), .rf_b(rf_b),
    .result(result), .flag_z(flag_z), .flag_c(flag_c), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        e;
    logic [15:0] res;
    logic        z, c;
    int          rd, wr, lat;
    logic [3:0]  da, aa, ba;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          wr_total = 0;
  logic [15:0] prev_res = 16'h0;
  logic        prev_z = 1'b0, prev_c = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pushes the expected retirement; illegal/NOP keep the previous result and flags.
  task automatic push_exp(input logic [3:0] op, da, aa, ba,
                          input logic [15:0] res, input logic z, c, e);
    exp_t x;
    logic legal;
    legal = (op != 4'h0) && !e;
    x.e   = e;
    x.res = legal ? res : prev_res;
    x.z   = legal ? z : prev_z;
    x.c   = legal ? c : prev_c;
    x.rd  = legal ? 1 : 0;
    x.wr  = legal ? 1 : 0;
    x.lat = legal ? 4 : 1;
    x.da  = da;
    x.aa  = aa;
    x.ba  = ba;
    if (legal) begin
      prev_res = res;
      prev_z   = z;
      prev_c   = c;
    end
    exp_q.push_back(x);
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("accept_wait", ok, 1'b1);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_queue", exp_q.size(), 0);
  endtask

  task automatic issue(input logic [3:0] op, da, aa, ba, input logic [15:0] a, b,
                       input logic [15:0] res, input logic z, c, e, input bit push);
    rf_a = a;
    rf_b = b;
    if (push) push_exp(op, da, aa, ba, res, z, c, e);
    instr       = {op, da, aa, ba};
    instr_valid = 1'b1;
    wait_accept();
    instr_valid = 1'b0;
    if (push) drain();
  endtask

  // Monitor: collects rf traffic per instruction and scores it on done.
  int         m_cyc = 0, m_rd = 0, m_wr = 0;
  bit         m_busy = 1'b0;
  logic [3:0] m_aa, m_ba, m_da;
  logic [15:0] m_d;

  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      m_busy = 1'b0;
      m_cyc  = 0;
      m_rd   = 0;
      m_wr   = 0;
    end else begin
      if (m_busy) m_cyc++;
      if (rf_en) begin
        if (rf_rw == 2'b10) begin
          m_rd++;
          m_aa = rf_aa;
          m_ba = rf_ba;
        end else if (rf_rw == 2'b01) begin
          m_wr++;
          wr_total++;
          m_da = rf_da;
          m_d  = rf_d;
        end else begin
          chk("rf_rw_code_with_en", {30'd0, rf_rw}, 32'd1);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", exp_q.size(), 1);
        end else begin
          x = exp_q.pop_front();
          chk("err", err, x.e);
          chk("result", result, x.res);
          chk("flag_z", flag_z, x.z);
          chk("flag_c", flag_c, x.c);
          chk("reads", m_rd, x.rd);
          chk("writes", m_wr, x.wr);
          chk("latency", m_cyc, x.lat);
          chk("done_rf_en", rf_en, 1'b0);
          chk("done_ready", instr_ready, 1'b1);
          if (x.rd > 0) chk("read_addr", {m_aa, m_ba}, {x.aa, x.ba});
          if (x.wr > 0) chk("write_da_d", {m_da, m_d}, {x.da, x.res});
        end
        m_busy = 1'b0;
        m_rd   = 0;
        m_wr   = 0;
      end else begin
        if (err) chk("err_without_done", err, 1'b0);
      end
      if (instr_valid && instr_ready) begin
        m_busy = 1'b1;
        m_cyc  = 0;
        m_rd   = 0;
        m_wr   = 0;
      end
    end
  end

  initial begin
    int wr_before;
    rst         = 1'b1;
    instr       = 16'h0;
    instr_valid = 1'b0;
    rf_a        = 16'h0;
    rf_b        = 16'h0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rf_en", rf_en, 1'b1);
      chk("rst_outputs", {instr_ready, done, err, flag_z, flag_c, rf_rw, rf_da, rf_aa, rf_ba},
          32'd0);
      chk("rst_data", {result, rf_d}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_rf_en", rf_en, 1'b0);
    chk("post_rst_ready", instr_ready, 1'b1);
    tick();

    //     op    da    aa    ba    a         b         res       z     c     e
    issue(4'h1, 4'd3, 4'd1, 4'd2, 16'h0005, 16'h0007, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'h2, 4'd4, 4'd1, 4'd2, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(4'h1, 4'd5, 4'd6, 4'd7, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(4'h3, 4'd8, 4'd9, 4'd10, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'h4, 4'd9, 4'd1, 4'd2, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'h5, 4'd10, 4'd1, 4'd2, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'h6, 4'd11, 4'd12, 4'd2, 16'h1234, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'h7, 4'd12, 4'd1, 4'd2, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'h8, 4'd13, 4'd1, 4'd2, 16'h8001, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'h9, 4'd14, 4'd1, 4'd2, 16'h8001, 16'h0000, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(4'hF, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef REGSEQ_MUL_EN
    issue(4'hC, 4'd2, 4'd3, 4'd4, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    issue(4'hC, 4'd2, 4'd3, 4'd4, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
`endif
    issue(4'h0, 4'd5, 4'd6, 4'd7, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    // Destination equals source A: the value read before the write is used.
    issue(4'h1, 4'd1, 4'd1, 4'd2, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back with instr_valid held: second accept lands in the done cycle.
    rf_a = 16'h00AA;
    rf_b = 16'h0055;
    push_exp(4'h5, 4'd6, 4'd1, 4'd2, 16'h00FF, 1'b0, 1'b0, 1'b0);
    instr       = {4'h5, 4'd6, 4'd1, 4'd2};
    instr_valid = 1'b1;
    wait_accept();
    push_exp(4'h2, 4'd7, 4'd3, 4'd4, 16'h0000, 1'b1, 1'b0, 1'b0);
    instr = {4'h2, 4'd7, 4'd3, 4'd4};
    for (int k = 1; k <= 3; k++) begin
      chk("busy_not_ready", instr_ready, 1'b0);
      if (k == 3) begin
        rf_a = 16'h0005;
        rf_b = 16'h0005;
      end
      tick();
    end
    chk("b2b_done_ready", {done, instr_ready}, 2'b11);
    tick();
    instr_valid = 1'b0;
    drain();

    // Reset during EXEC must abort without a write-back.
    issue(4'h6, 4'd9, 4'd8, 4'd2, 16'hBEEF, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
    wr_before = wr_total;
    issue(4'h1, 4'd3, 4'd1, 4'd2, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rf_en", rf_en, 1'b1);
    chk("mid_rst_outputs", {instr_ready, done, err, flag_z, flag_c, rf_rw}, 32'd0);
    chk("mid_rst_result", result, 16'h0000);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rst_no_write", wr_total, wr_before);
    chk("mid_rst_idle", {instr_ready, rf_en, done}, 3'b100);
    chk("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
